lab4_branch_pht_sched: RTL and testbench
========================================

LAB4_BRANCH_PHT_SCHED -- requirements
Module: lab4_branch_pht_sched

Interface
REQ-001 SHALL have parameter PHT_size, default 2048, number of 2-bit PHT counters (power of two); IDXW = log2(PHT_size).
REQ-002 SHALL have parameter UBUF_DEPTH, default 4, update-buffer entries (power of two, >=2).
REQ-003 SHALL have parameter STARVE_MAX, default 8, consecutive lookup-won cycles before a buffered update is forced.
REQ-004 SHALL have ports, one clock, reset asynchronous active-low:
  clk  in  1  clock
  reset  in  1  asynchronous, active-low reset
  flush  in  1  discard pending updates and re-initialise the PHT
  lookup_val  in  1  fetch lookup request
  lookup_rdy  out  1  lookup accepted this cycle
  lookup_idx  in  IDXW  lookup index
  lookup_resp_val  out  1  prediction valid
  lookup_resp_taken  out  1  prediction
  update_val  in  1  resolved-branch update request
  update_rdy  out  1  update buffer not full
  update_idx  in  IDXW  update index
  update_taken  in  1  resolved direction
  pht_en  out  1  PHT port access
  pht_wen  out  1  PHT write
  pht_addr  out  IDXW  PHT address
  pht_wdata  out  2  PHT write data
  pht_rdata  in  2  PHT read data, valid the cycle after a read
  init_busy  out  1  initialisation walk in progress

Function
REQ-005 SHALL use states INIT, RUN, UPD_WR; exactly one PHT access (pht_en) per cycle, at most.
REQ-006 INIT SHALL write 2'b01 (weakly not-taken) to addresses 0..PHT_size-1, one per cycle; init_busy=1; lookup_rdy=update_rdy=0; INIT->RUN after writing address PHT_size-1.
REQ-007 Update transfer SHALL occur when update_val && update_rdy; update_rdy = !init_busy && buffer not full; entries enter a FIFO.
REQ-008 RUN port grant: if buffer non-empty and (buffer full, or !lookup_val, or starve count == STARVE_MAX), grant update; else if lookup_val, grant lookup.
REQ-009 Lookup grant at cycle t: lookup_rdy=1, pht_en=1, pht_wen=0, pht_addr=lookup_idx; at t+1 lookup_resp_val=1, lookup_resp_taken=pht_rdata[1].
REQ-010 Update grant at cycle t: read head index, go to UPD_WR; at t+1 write head index with taken ? min(cnt+1,3) : max(cnt-1,0), pop head, return to RUN; lookup_rdy=0 in UPD_WR.
REQ-011 Starve count SHALL increment when a lookup is granted while buffer non-empty, clear on update grant or empty buffer, saturate at STARVE_MAX.
REQ-012 A buffer push and pop in the same cycle SHALL both take effect; a full buffer accepts no push even while popping.
REQ-013 Lookups SHALL return the stored counter; pending buffered updates are not forwarded.
REQ-014 flush=1 in any state SHALL, next cycle: empty the buffer, clear starve count, suppress any pending UPD_WR write, enter INIT at address 0; flush during INIT restarts at address 0.
REQ-015 A lookup granted in the cycle before flush SHALL still produce its response.

Reset
REQ-016 On reset low: state INIT, init address 0, buffer empty, starve count 0, lookup_resp_val=0, pht_en=0, init_busy=1 after release.
REQ-017 Reset assertion mid-RMW SHALL abandon the write; no partial PHT write.

Configuration
REQ-018 Macro LAB4_BRANCH_PHT_STARVE_EN defined: starvation counter and REQ-008 forcing active.
REQ-019 Macro undefined: no starve counter; updates granted only when buffer full or !lookup_val.

Structure
REQ-020 Package lab4_branch_pht_pkg SHALL hold state enum, 2-bit counter typedef, WEAK_NT=2'b01, CNT_MAX=2'b11.
REQ-021 FIFO SHALL be sub-module lab4_branch_pht_ubuf (push/pop/full/empty, {idx,taken} entries).

Verification
REQ-022 Reset release, PHT_size=16 -> 16 writes of 2'b01 to addr 0..15, init_busy low at cycle 16.
REQ-023 Update idx 5 taken x2 then lookup idx 5 -> response taken=1 (counter 2'b11); third taken leaves 2'b11.
REQ-024 lookup_val held high, one update buffered, STARVE_EN -> update granted after exactly 8 lookups; without macro only when lookup_val drops.
REQ-025 Four updates with lookup_val high -> update_rdy=0 on 5th, next cycle update granted over lookup.
REQ-026 flush asserted during UPD_WR -> no write, buffer empty, INIT restarts at addr 0.

Source files
------------

// File: rtl/lab4_branch_pht_pkg.sv
// Shared types and constants for the branch PHT scheduler.
// Contents:
//   state_e  - scheduler FSM states (INIT, RUN, UPD_WR)
//   cnt_t    - 2-bit saturating prediction counter
//   WEAK_NT  - counter value written by the initialisation walk
//   CNT_MAX  - saturation ceiling of the counter
//   cnt_next - saturating increment/decrement toward the resolved direction
package lab4_branch_pht_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    UPD_WR = 2'd2
  } state_e;

  typedef logic [1:0] cnt_t;

  localparam cnt_t WEAK_NT = 2'b01;
  localparam cnt_t CNT_MAX = 2'b11;

  function automatic cnt_t cnt_next(input cnt_t cnt, input logic taken);
    if (taken) return (cnt == CNT_MAX) ? cnt : cnt + 2'd1;
    else       return (cnt == 2'b00)   ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/lab4_branch_pht_sched_if.sv
// Bus bundle for the branch PHT scheduler: fetch lookup channel, resolved
// branch update channel and the single-ported PHT access port.
// Modports:
//   slave  - the scheduler (accepts lookups/updates, drives the PHT port)
//   master - the environment (fetch, branch resolution and the PHT storage)
interface lab4_branch_pht_sched_if
  import lab4_branch_pht_pkg::*;
#(
  parameter int IDXW = 11
);

  logic            lookup_val;
  logic            lookup_rdy;
  logic [IDXW-1:0] lookup_idx;
  logic            lookup_resp_val;
  logic            lookup_resp_taken;
  logic            update_val;
  logic            update_rdy;
  logic [IDXW-1:0] update_idx;
  logic            update_taken;
  logic            pht_en;
  logic            pht_wen;
  logic [IDXW-1:0] pht_addr;
  cnt_t            pht_wdata;
  cnt_t            pht_rdata;

  modport slave (
    input  lookup_val, lookup_idx, update_val, update_idx, update_taken, pht_rdata,
    output lookup_rdy, lookup_resp_val, lookup_resp_taken, update_rdy,
           pht_en, pht_wen, pht_addr, pht_wdata
  );

  modport master (
    output lookup_val, lookup_idx, update_val, update_idx, update_taken, pht_rdata,
    input  lookup_rdy, lookup_resp_val, lookup_resp_taken, update_rdy,
           pht_en, pht_wen, pht_addr, pht_wdata
  );

endinterface

// File: rtl/lab4_branch_pht_ubuf.sv
// Update buffer: FIFO of resolved-branch updates waiting for a PHT slot.
// Ports:
//   clk, reset (async, active-low), flush (synchronous clear)
//   push/din   - enqueue an entry; ignored while full, even if popping
//   pop/dout   - dequeue the head; dout always shows the current head
//   full/empty - occupancy flags
// Entries are {idx, taken}, W bits wide. DEPTH must be a power of two >= 2.
module lab4_branch_pht_ubuf #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && !full;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok)         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop && !empty)   rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/lab4_branch_pht_sched.sv
// Branch PHT scheduler: arbitrates a single-ported table of 2-bit counters
// between fetch lookups and buffered resolved-branch updates.
// Ports:
//   clk, reset (async, active-low)
//   flush      - drop pending updates and re-run the initialisation walk
//   bus        - lookup / update channels and the PHT port (slave modport)
//   init_busy  - high while the table is being initialised
// After reset or flush every counter is written to weakly not-taken, one
// address per cycle. In RUN each cycle grants at most one PHT access; an
// update is a read followed by a write (UPD_WR) of the adjusted counter.
// Lookups see only committed counters; buffered updates are not forwarded.
// Configuration macro: LAB4_BRANCH_PHT_STARVE_EN - when defined, an update
// waiting behind STARVE_MAX consecutive lookup grants is forced through.
module lab4_branch_pht_sched
  import lab4_branch_pht_pkg::*;
#(
  parameter int PHT_size   = 2048,
  parameter int UBUF_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  lab4_branch_pht_sched_if.slave  bus,
  output logic                    init_busy
);

  localparam int IDXW = $clog2(PHT_size);

  state_e          state_q, state_d;
  logic [IDXW-1:0] init_addr_q, init_addr_d;
  logic            resp_val_q, resp_val_d;

  logic            buf_push, buf_pop, buf_full, buf_empty;
  logic [IDXW-1:0] head_idx;
  logic            head_taken;
  logic            starve_hit;

  logic            lookup_rdy;
  logic            pht_en, pht_wen;
  logic [IDXW-1:0] pht_addr;
  cnt_t            pht_wdata;

  assign init_busy = (state_q == INIT);
  assign bus.update_rdy = !init_busy && !buf_full;
  assign buf_push = bus.update_val && bus.update_rdy;

  lab4_branch_pht_ubuf #(
    .DEPTH (UBUF_DEPTH),
    .W     (IDXW + 1)
  ) u_ubuf (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (buf_push),
    .din   ({bus.update_idx, bus.update_taken}),
    .pop   (buf_pop),
    .dout  ({head_idx, head_taken}),
    .full  (buf_full),
    .empty (buf_empty)
  );

`ifdef LAB4_BRANCH_PHT_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign starve_hit = (starve_q == SW'(STARVE_MAX));

  // Counts lookups that overtook a waiting update; any update grant or an
  // empty buffer means nothing is being starved.
  always_comb begin
    starve_d = starve_q;
    if (flush || buf_empty || state_d == UPD_WR) starve_d = '0;
    else if (lookup_rdy && !starve_hit)          starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    resp_val_d  = 1'b0;
    lookup_rdy  = 1'b0;
    buf_pop     = 1'b0;
    pht_en      = 1'b0;
    pht_wen     = 1'b0;
    pht_addr    = '0;
    pht_wdata   = '0;

    unique case (state_q)
      INIT: begin
        pht_en      = 1'b1;
        pht_wen     = 1'b1;
        pht_addr    = init_addr_q;
        pht_wdata   = WEAK_NT;
        init_addr_d = init_addr_q + IDXW'(1);
        if (init_addr_q == IDXW'(PHT_size - 1)) state_d = RUN;
      end
      RUN: begin
        if (!buf_empty && (buf_full || !bus.lookup_val || starve_hit)) begin
          pht_en   = 1'b1;
          pht_addr = head_idx;
          state_d  = UPD_WR;
        end else if (bus.lookup_val) begin
          lookup_rdy = 1'b1;
          pht_en     = 1'b1;
          pht_addr   = bus.lookup_idx;
          resp_val_d = 1'b1;
        end
      end
      UPD_WR: begin
        // pht_rdata holds the head counter read in the previous cycle.
        pht_en    = 1'b1;
        pht_wen   = 1'b1;
        pht_addr  = head_idx;
        pht_wdata = cnt_next(bus.pht_rdata, head_taken);
        buf_pop   = 1'b1;
        state_d   = RUN;
      end
      default: state_d = INIT;
    endcase

    // Flush takes the port away this cycle, which also kills a pending
    // UPD_WR write; the walk restarts at address 0 next cycle.
    if (flush) begin
      state_d     = INIT;
      init_addr_d = '0;
      resp_val_d  = 1'b0;
      lookup_rdy  = 1'b0;
      buf_pop     = 1'b0;
      pht_en      = 1'b0;
      pht_wen     = 1'b0;
    end

    // The port stays quiet for the whole reset assertion, so a reset landing
    // in UPD_WR never commits a write.
    if (!reset) begin
      pht_en  = 1'b0;
      pht_wen = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      init_addr_q <= '0;
      resp_val_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      resp_val_q  <= resp_val_d;
    end
  end

  assign bus.lookup_rdy        = lookup_rdy;
  assign bus.lookup_resp_val   = resp_val_q;
  assign bus.lookup_resp_taken = bus.pht_rdata[1];
  assign bus.pht_en            = pht_en;
  assign bus.pht_wen           = pht_wen;
  assign bus.pht_addr          = pht_addr;
  assign bus.pht_wdata         = pht_wdata;

endmodule

// File: tb/tb_lab4_branch_pht_sched.sv
// Directed bench for lab4_branch_pht_sched with a 16-entry PHT.
// The bench owns the PHT storage (registered read, one-cycle latency).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
module tb_lab4_branch_pht_sched;
  import lab4_branch_pht_pkg::*;

  localparam int PHT_SIZE = 16;
  localparam int IDXW     = 4;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic init_busy;

  int checks = 0;
  int errors = 0;

  lab4_branch_pht_sched_if #(.IDXW(IDXW)) bus ();

  lab4_branch_pht_sched #(
    .PHT_size   (PHT_SIZE),
    .UBUF_DEPTH (4),
    .STARVE_MAX (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  // PHT storage seen by the scheduler.
  cnt_t mem [PHT_SIZE];
  cnt_t rdata_r;
  assign bus.pht_rdata = rdata_r;

  always @(posedge clk) begin
    if (bus.pht_en) begin
      if (bus.pht_wen) mem[bus.pht_addr] <= bus.pht_wdata;
      else             rdata_r <= mem[bus.pht_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks the 16-cycle initialisation with both request inputs high to show
  // they are held off; ends in the first RUN cycle.
  task automatic do_init(input string tag);
    bus.lookup_val = 1'b1;
    bus.update_val = 1'b1;
    for (int i = 0; i < PHT_SIZE; i++) begin
      #1;
      check({tag, "_busy"}, init_busy, 1);
      check({tag, "_wr"}, {bus.pht_en, bus.pht_wen, bus.pht_wdata}, {2'b11, WEAK_NT});
      check({tag, "_addr"}, bus.pht_addr, i);
      check({tag, "_rdy"}, {bus.lookup_rdy, bus.update_rdy}, 2'b00);
      tick();
    end
    bus.lookup_val = 1'b0;
    bus.update_val = 1'b0;
    #1;
    check({tag, "_done"}, init_busy, 0);
  endtask

  // Buffer one update with no lookup competing, then follow the read and write.
  task automatic do_update(input logic [3:0] idx, input logic taken, input cnt_t exp_w);
    bus.update_val   = 1'b1;
    bus.update_idx   = idx;
    bus.update_taken = taken;
    #1;
    check("upd_push_rdy", bus.update_rdy, 1);
    tick();
    bus.update_val = 1'b0;
    #1;
    check("upd_rd", {bus.pht_en, bus.pht_wen, bus.pht_addr}, {2'b10, idx});
    tick();
    #1;
    check("upd_wr", {bus.pht_en, bus.pht_wen, bus.pht_addr, bus.pht_wdata}, {2'b11, idx, exp_w});
    check("upd_wr_lrdy", bus.lookup_rdy, 0);
    tick();
  endtask

  task automatic do_lookup(input logic [3:0] idx, input logic exp_taken);
    bus.lookup_val = 1'b1;
    bus.lookup_idx = idx;
    #1;
    check("lk_grant", {bus.lookup_rdy, bus.pht_en, bus.pht_wen, bus.pht_addr}, {3'b110, idx});
    tick();
    bus.lookup_val = 1'b0;
    #1;
    check("lk_resp", {bus.lookup_resp_val, bus.lookup_resp_taken}, {1'b1, exp_taken});
    tick();
  endtask

  initial begin
    int  n_lk;
    bit  got_upd;

    reset            = 1'b0;
    flush            = 1'b0;
    bus.lookup_val   = 1'b0;
    bus.lookup_idx   = '0;
    bus.update_val   = 1'b0;
    bus.update_idx   = '0;
    bus.update_taken = 1'b0;

    // Reset state.
    repeat (3) tick();
    #1;
    check("rst_pht_en", bus.pht_en, 0);
    check("rst_resp_val", bus.lookup_resp_val, 0);
    check("rst_init_busy", init_busy, 1);
    check("rst_update_rdy", bus.update_rdy, 0);
    tick();
    reset = 1'b1;

    do_init("init");
    for (int i = 0; i < PHT_SIZE; i++) check("init_mem", mem[i], WEAK_NT);
    check("idle_run", bus.pht_en, 0);

    // Saturating counter behaviour: 01 -> 10 -> 11 -> 11 -> 10, and 01 -> 00 -> 00.
    do_update(4'd5, 1'b1, 2'b10);
    check("mem5_a", mem[5], 2'b10);
    do_update(4'd5, 1'b1, 2'b11);
    do_lookup(4'd5, 1'b1);
    do_update(4'd5, 1'b1, 2'b11);
    check("mem5_sat", mem[5], 2'b11);
    do_update(4'd5, 1'b0, 2'b10);
    do_update(4'd3, 1'b0, 2'b00);
    do_update(4'd3, 1'b0, 2'b00);
    do_lookup(4'd3, 1'b0);
    do_lookup(4'd5, 1'b1);

    // Update waiting behind a continuous lookup stream to the same index.
    bus.update_val   = 1'b1;
    bus.update_idx   = 4'd7;
    bus.update_taken = 1'b1;
    #1;
    check("stv_push_rdy", bus.update_rdy, 1);
    tick();
    bus.update_val = 1'b0;
    bus.lookup_val = 1'b1;
    bus.lookup_idx = 4'd7;
    n_lk    = 0;
    got_upd = 1'b0;
    for (int c = 0; c < 30 && !got_upd; c++) begin
      #1;
      if (bus.lookup_resp_val) check("stv_no_fwd", bus.lookup_resp_taken, 0);
      if (bus.lookup_rdy) n_lk++;
      else if (bus.pht_en && !bus.pht_wen) begin
        got_upd = 1'b1;
        check("stv_rd_addr", bus.pht_addr, 7);
      end
      tick();
    end
`ifdef LAB4_BRANCH_PHT_STARVE_EN
    check("stv_forced", got_upd, 1);
    check("stv_lookups", n_lk, 8);
`else
    check("stv_held", got_upd, 0);
    check("stv_lookups", n_lk, 30);
    bus.lookup_val = 1'b0;
    #1;
    check("stv_drop_grant", {bus.pht_en, bus.pht_wen, bus.pht_addr}, {2'b10, 4'd7});
    tick();
`endif
    bus.lookup_val = 1'b0;
    #1;
    check("stv_wr", {bus.pht_en, bus.pht_wen, bus.pht_addr, bus.pht_wdata}, {2'b11, 4'd7, 2'b10});
    check("stv_wr_lrdy", bus.lookup_rdy, 0);
    tick();

    // Fill the buffer while lookups keep flowing; a full buffer wins the port.
    bus.lookup_val = 1'b1;
    bus.lookup_idx = 4'd0;
    for (int i = 0; i < 4; i++) begin
      bus.update_val   = 1'b1;
      bus.update_idx   = 4'(8 + i);
      bus.update_taken = (i != 1);
      #1;
      check("fill_rdy", {bus.update_rdy, bus.lookup_rdy}, 2'b11);
      tick();
    end
    bus.update_idx   = 4'd12;
    bus.update_taken = 1'b1;
    #1;
    check("full_update_rdy", bus.update_rdy, 0);
    check("full_grant", {bus.lookup_rdy, bus.pht_en, bus.pht_wen, bus.pht_addr}, {3'b010, 4'd8});
    tick();
    #1;
    check("full_wr_rdy", bus.update_rdy, 0);
    check("full_wr", {bus.pht_en, bus.pht_wen, bus.pht_addr, bus.pht_wdata}, {2'b11, 4'd8, 2'b10});
    tick();
    bus.update_val = 1'b0;
    #1;
    check("after_full_lookup", bus.lookup_rdy, 1);
    tick();
    bus.lookup_val = 1'b0;
    repeat (6) tick();
    #1;
    check("drained_idle", bus.pht_en, 0);
    check("mem9", mem[9], 2'b00);
    check("mem10", mem[10], 2'b10);
    check("mem11", mem[11], 2'b10);
    check("mem12_dropped", mem[12], WEAK_NT);

    // A lookup granted just before flush still returns its response.
    bus.lookup_val = 1'b1;
    bus.lookup_idx = 4'd5;
    #1;
    check("pf_grant", bus.lookup_rdy, 1);
    tick();
    bus.lookup_val = 1'b0;
    flush = 1'b1;
    #1;
    check("pf_resp", {bus.lookup_resp_val, bus.lookup_resp_taken}, 2'b11);
    check("pf_no_access", bus.pht_en, 0);
    tick();
    flush = 1'b0;
    do_init("reinit1");

    // Flush in UPD_WR with a second entry still queued.
    bus.update_val   = 1'b1;
    bus.update_idx   = 4'd2;
    bus.update_taken = 1'b1;
    tick();
    bus.update_idx   = 4'd4;
    #1;
    check("fw_rd", {bus.pht_en, bus.pht_wen, bus.pht_addr}, {2'b10, 4'd2});
    tick();
    bus.update_val = 1'b0;
    flush = 1'b1;
    #1;
    check("fw_no_write", bus.pht_en, 0);
    tick();
    flush = 1'b0;
    #1;
    check("fw_mem2", mem[2], WEAK_NT);
    do_init("reinit2");
    repeat (3) begin
      #1;
      check("fw_buf_empty", bus.pht_en, 0);
      tick();
    end
    check("fw_mem4", mem[4], WEAK_NT);

    // Reset landing in UPD_WR abandons the write.
    bus.update_val   = 1'b1;
    bus.update_idx   = 4'd6;
    bus.update_taken = 1'b1;
    tick();
    bus.update_val = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("rmw_rst_en", bus.pht_en, 0);
    tick();
    check("rmw_rst_mem6", mem[6], WEAK_NT);
    check("rmw_rst_resp", bus.lookup_resp_val, 0);
    reset = 1'b1;
    do_init("reinit3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
